ad_adc_channel_core: RTL

// - Parametrised per-channel ADC datapath: N samples/clock, data formatting, PN9/PN23 monitor

---
 rtl/ad_adc_channel_core.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ad_adc_channel_core.sv
// ad_adc_channel_core
//   Per-channel ADC datapath in adc_clk. It formats SAMPLES_PER_CLK samples per
//   beat, runs a self-synchronising PN9/PN23 monitor with a lock FSM, and keeps
//   over-range and PN error statistics.
//   Optional feature: define AD_ADC_CHANNEL_PEAK_EN to add adc_peak, the peak
//   |sample| tracker.
// Ports
//   adc_clk, adc_rstn         clock, async active-low reset
//   adc_valid/adc_data/adc_or input beat, lane n at [n*DW +: DW], over-range flag
//   cfg_dfmt_*                format enable / offset-binary / sign-extend
//   cfg_pnseq_sel             0 PN9, 1 PN23, 2/3 monitor off
//   cfg_stat_clr              clears counters, sticky flag, peak and the PN seed
//   adc_dfmt_valid/data       formatted samples, 1-cycle latency
//   adc_pn_oos, adc_pn_err    lock status, per-beat error pulse while locked
//   adc_pn_err_cnt, adc_or_cnt, adc_or_sticky   saturating statistics
//   adc_peak                  (AD_ADC_CHANNEL_PEAK_EN only) peak |formatted sample|

module ad_adc_channel_fmt #(
  parameter int DW = 14,
  parameter int OW = 16
) (
  input  logic [DW-1:0] raw,
  input  logic          enable,
  input  logic          off_bin,
  input  logic          se,
  output logic [OW-1:0] fmt
);
  logic m;
  always_comb begin
    m = raw[DW-1] ^ off_bin;
    fmt = '0;
    if (!enable) begin
      fmt[DW-1:0] = raw;
    end else begin
      fmt[DW-1:0] = {m, raw[DW-2:0]};
      for (int i = DW; i < OW; i++) fmt[i] = se & m;
    end
  end
endmodule

module ad_adc_channel_core #(
  parameter int SAMPLES_PER_CLK = 2,
  parameter int DATA_WIDTH      = 14,
  parameter int OUT_WIDTH       = 16,
  parameter int LOCK_COUNT      = 16
) (
  input  logic                                 adc_clk,
  input  logic                                 adc_rstn,
  input  logic                                 adc_valid,
  input  logic [SAMPLES_PER_CLK*DATA_WIDTH-1:0] adc_data,
  input  logic                                 adc_or,
  input  logic                                 cfg_dfmt_enable,
  input  logic                                 cfg_dfmt_type,
  input  logic                                 cfg_dfmt_se,
  input  logic [1:0]                           cfg_pnseq_sel,
  input  logic                                 cfg_stat_clr,
  output logic                                 adc_dfmt_valid,
  output logic [SAMPLES_PER_CLK*OUT_WIDTH-1:0] adc_dfmt_data,
  output logic                                 adc_pn_oos,
  output logic                                 adc_pn_err,
  output logic [31:0]                          adc_pn_err_cnt,
  output logic                                 adc_or_sticky,
  output logic [15:0]                          adc_or_cnt
`ifdef AD_ADC_CHANNEL_PEAK_EN
  ,output logic [OUT_WIDTH-1:0]                adc_peak
`endif
);
  localparam int SPC = SAMPLES_PER_CLK;
  localparam int DW  = DATA_WIDTH;
  localparam int OW  = OUT_WIDTH;
  localparam int W   = SPC * DW;
  localparam logic [7:0] LC_LAST = 8'(LOCK_COUNT - 1);

  // ---------------- format ----------------
  logic [SPC-1:0][OW-1:0] fmt_c, dfmt_q;

  for (genvar n = 0; n < SPC; n++) begin : g_lane
    ad_adc_channel_fmt #(.DW(DW), .OW(OW)) u_fmt (
      .raw     (adc_data[n*DW +: DW]),
      .enable  (cfg_dfmt_enable),
      .off_bin (cfg_dfmt_type),
      .se      (cfg_dfmt_se),
      .fmt     (fmt_c[n])
    );
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      adc_dfmt_valid <= 1'b0;
      dfmt_q         <= '0;
    end else begin
      adc_dfmt_valid <= adc_valid;
      if (adc_valid) dfmt_q <= fmt_c;
    end
  end
  assign adc_dfmt_data = dfmt_q;

  // ---------------- PN monitor ----------------
  // Bit k of a stream vector is the k-th bit in time: lane 0 first, MSB first.
  typedef enum logic {ST_OOS, ST_SYNC} state_t;
  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [W-1:0] prev_q, prev_d, cur_s, exp_s;
  logic [2*W-1:0] seq;
  logic         prev_vld_q, prev_vld_d, err_d, pn_match;
  logic [1:0]   sel_q;

  always_comb begin
    cur_s = '0;
    for (int j = 0; j < W; j++) cur_s[j] = adc_data[(j/DW)*DW + DW-1 - (j%DW)];
    // Continue the sequence from the previous received beat; W >= 23 so it
    // always holds a full seed.
    seq = '0;
    seq[W-1:0] = prev_q;
    for (int k = W; k < 2*W; k++)
      seq[k] = cfg_pnseq_sel[0] ? (seq[k-23] ^ seq[k-18]) : (seq[k-9] ^ seq[k-5]);
    exp_s = seq[2*W-1:W];
    // all-zero is the LFSR lock-up state and never counts as a match
    pn_match = (cur_s == exp_s) && (|cur_s);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    err_d      = 1'b0;
    if (cfg_pnseq_sel[1] || (cfg_pnseq_sel != sel_q)) begin
      state_d    = ST_OOS;
      cnt_d      = '0;
      prev_vld_d = 1'b0;
    end else if (cfg_stat_clr) begin
      prev_vld_d = 1'b0;
    end else if (adc_valid) begin
      prev_d     = cur_s;
      prev_vld_d = 1'b1;
      if (prev_vld_q) begin
        if (state_q == ST_OOS) begin
          if (!pn_match)              cnt_d = '0;
          else if (cnt_q == LC_LAST) begin state_d = ST_SYNC; cnt_d = '0; end
          else                        cnt_d = cnt_q + 8'd1;
        end else begin
          if (pn_match) cnt_d = '0;
          else begin
            err_d = 1'b1;
            if (cnt_q == LC_LAST) begin state_d = ST_OOS; cnt_d = '0; end
            else                        cnt_d = cnt_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_q    <= ST_OOS;
      cnt_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      sel_q      <= '0;
      adc_pn_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      sel_q      <= cfg_pnseq_sel;
      adc_pn_err <= err_d;
    end
  end
  assign adc_pn_oos = (state_q == ST_OOS);

  // ---------------- statistics ----------------
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      adc_pn_err_cnt <= '0;
      adc_or_cnt     <= '0;
      adc_or_sticky  <= 1'b0;
    end else if (cfg_stat_clr) begin
      adc_pn_err_cnt <= '0;
      adc_or_cnt     <= '0;
      adc_or_sticky  <= 1'b0;
    end else begin
      if (err_d && (adc_pn_err_cnt != '1)) adc_pn_err_cnt <= adc_pn_err_cnt + 32'd1;
      if (adc_valid && adc_or) begin
        adc_or_sticky <= 1'b1;
        if (adc_or_cnt != '1) adc_or_cnt <= adc_or_cnt + 16'd1;
      end
    end
  end

`ifdef AD_ADC_CHANNEL_PEAK_EN
  localparam logic [OW-1:0] MOST_NEG = {1'b1, {(OW-1){1'b0}}};
  logic [OW-1:0] pk_c, mag;
  always_comb begin
    pk_c = '0;
    mag  = '0;
    for (int n = 0; n < SPC; n++) begin
      if (cfg_dfmt_se && dfmt_q[n][OW-1])
        mag = (dfmt_q[n] == MOST_NEG) ? ~MOST_NEG : -dfmt_q[n];
      else
        mag = dfmt_q[n];
      if (mag > pk_c) pk_c = mag;
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn)                             adc_peak <= '0;
    else if (cfg_stat_clr)                     adc_peak <= '0;
    else if (adc_dfmt_valid && pk_c > adc_peak) adc_peak <= pk_c;
  end
`else
  // peak tracking not built
`endif
endmodule
